// File: rtl/mul_seq_32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier. One partial-product
// addition per clock through a single ripple-carry adder instance.

module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        Pin,
  output logic [31:0] S,
  output logic        Pout
);
  logic [32:0] w_c;

  assign w_c[0] = Pin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign S[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign Pout = w_c[32];
endmodule

module mul_seq_32 #(
  parameter int WIDTH     = 32,
  parameter int ZERO_SKIP = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [63:0] res_o,
  output logic        busy_o
);
  if (WIDTH != 32) begin : g_width_chk
    $error("mul_seq_32: WIDTH must be 32, the adder instance is fixed-width");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic        r_req_ready;
  logic        r_res_valid;
  logic        r_busy;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_accept;
  logic        w_zero;

  assign w_addend = r_lo[0] ? r_mcand : 32'd0;

  adder_32bit u_add (
    .a    (r_hi),
    .b    (w_addend),
    .Pin  (1'b0),
    .S    (w_sum),
    .Pout (w_cout)
  );

  // req_ready is registered, so nothing is accepted in the first cycle after reset
  assign w_accept = req_valid_i && r_req_ready;
  assign w_zero   = (ZERO_SKIP != 0) && ((a_i == 32'd0) || (b_i == 32'd0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_zero ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == 6'd31) w_state_nxt = S_DONE;
      S_DONE: if (res_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mcand     <= 32'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_cnt       <= 6'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_BUSY);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= a_i;
            r_hi    <= 32'd0;
            r_lo    <= w_zero ? 32'd0 : b_i;
            r_cnt   <= 6'd0;
          end
        end
        S_BUSY: begin
          // Carry-out becomes hi[31]; the sum LSB shifts into lo as multiplier bits retire
          {r_hi, r_lo} <= {w_cout, w_sum, r_lo[31:1]};
          r_cnt        <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign res_valid_o = r_res_valid;
  assign busy_o      = r_busy;
  assign res_o       = {r_hi, r_lo};
endmodule
